jtcontra_snd_cmd: RTL and testbench

- Main-CPU-side sound command transmitter; the producing end of the snd_latch/snd_irq link into the sound subsystem.
- Buffers main CPU command bytes in a small FIFO.
- Presents one byte at a time on snd_latch and raises a snd_irq pulse for each byte. The sound side's edge-triggered interrupt flip-flop sees one rising edge per command.
- Waits for the sound CPU to read the latch, or for a timeout, before sending the next byte.

---
 rtl/jtcontra_snd_cmd.sv | 140 ++++++++++++++
 tb/tb_jtcontra_snd_cmd.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtcontra_snd_cmd.sv
// Main-CPU side sound command transmitter: queues command bytes and hands them
// one at a time to the sound CPU through snd_latch with an snd_irq pulse each.
module jtcontra_snd_cmd #(
  parameter int AW      = 2,
  parameter int IRQ_LEN = 16,
  parameter int GAP_LEN = 4,
  parameter int TOUT    = 65535
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cpu_dout,
  input  logic       latch_we,
  input  logic       snd_rd,
  output logic [7:0] snd_latch,
  output logic       snd_irq,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       ovf,
  output logic       tout
);

  localparam int              DEPTH     = 1 << AW;
  localparam logic [AW:0]     FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [15:0]     IRQ_LAST  = 16'(IRQ_LEN - 1);
  localparam logic [15:0]     GAP_LAST  = 16'(GAP_LEN - 1);
  localparam logic [15:0]     TOUT_LAST = 16'((TOUT == 0) ? 0 : TOUT - 1);

  typedef enum logic [1:0] {IDLE, IRQ, WAIT_RD, GAP} state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nx;
  logic          we_prev, rd_prev;
  logic          push, push_ok, pop, rd_ev;
  logic [15:0]   cnt, cnt_nx, timer, timer_nx;
  logic          rd_seen, rd_seen_nx, irq_nx, tout_hit;

  assign push    = latch_we & ~we_prev;
  assign rd_ev   = snd_rd & ~rd_prev;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits
  assign push_ok = push && ((count != FULL_CNT) || pop);

  always_comb begin
    count_nx = count + (AW+1)'(push_ok) - (AW+1)'(pop);
  end

  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    irq_nx     = snd_irq;
    cnt_nx     = cnt;
    timer_nx   = timer;
    rd_seen_nx = rd_seen;
    tout_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          irq_nx     = 1'b1;
          rd_seen_nx = 1'b0;
          timer_nx   = '0;
          cnt_nx     = '0;
          state_nx   = IRQ;
        end
      end
      IRQ: begin
        if (rd_ev) rd_seen_nx = 1'b1;
        if (cnt == IRQ_LAST) begin
          irq_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = WAIT_RD;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      WAIT_RD: begin
        // The timeout fires on the TOUT-th cycle spent waiting here
        if (rd_seen || rd_ev) begin
          cnt_nx   = '0;
          state_nx = GAP;
        end else if ((TOUT != 0) && (timer == TOUT_LAST)) begin
          tout_hit = 1'b1;
          cnt_nx   = '0;
          state_nx = GAP;
        end else begin
          timer_nx = timer + 16'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) state_nx = IDLE;
        else                 cnt_nx   = cnt + 16'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= cpu_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      we_prev    <= 1'b0;
      rd_prev    <= 1'b0;
      cnt        <= '0;
      timer      <= '0;
      rd_seen    <= 1'b0;
      snd_latch  <= 8'd0;
      snd_irq    <= 1'b0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      ovf        <= 1'b0;
      tout       <= 1'b0;
    end else begin
      state      <= state_nx;
      we_prev    <= latch_we;
      rd_prev    <= snd_rd;
      cnt        <= cnt_nx;
      timer      <= timer_nx;
      rd_seen    <= rd_seen_nx;
      snd_irq    <= irq_nx;
      count      <= count_nx;
      fifo_empty <= (count_nx == '0);
      fifo_full  <= (count_nx == FULL_CNT);
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        snd_latch <= mem[rd_ptr];
      end
      if (push && !push_ok) ovf  <= 1'b1;
      if (tout_hit)         tout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtcontra_snd_cmd.sv
// Directed bench for jtcontra_snd_cmd: irq framing, ordering, timeout, overflow, reset.
`timescale 1ns/1ps
module tb_jtcontra_snd_cmd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cpu_dout = 8'd0;
  logic       latch_we = 1'b0;
  logic       snd_rd = 1'b0;
  logic [7:0] snd_latch;
  logic       snd_irq, fifo_empty, fifo_full, ovf, tout;

  int errors = 0;
  int checks = 0;

  // Monitor state: every snd_irq rising edge records the byte and its cycle
  int         cyc = 0;
  logic       irq_q = 1'b0;
  int         last_len = 0;
  logic [7:0] rise_bytes[$];
  int         rise_times[$];

  jtcontra_snd_cmd #(.AW(2), .IRQ_LEN(16), .GAP_LEN(4), .TOUT(32)) dut (
    .clk(clk), .rst(rst), .cpu_dout(cpu_dout), .latch_we(latch_we), .snd_rd(snd_rd),
    .snd_latch(snd_latch), .snd_irq(snd_irq), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .ovf(ovf), .tout(tout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (snd_irq && !irq_q) begin
      rise_bytes.push_back(snd_latch);
      rise_times.push_back(cyc);
    end
    if (!snd_irq && irq_q && rise_times.size() > 0) last_len = cyc - rise_times[$];
    irq_q = snd_irq;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One write strobe: one cycle high, one cycle low
  task automatic applyStimulus(input logic [7:0] d);
    cpu_dout = d;
    latch_we = 1'b1;
    tick();
    latch_we = 1'b0;
    tick();
  endtask

  task automatic waitRise(input int n, input int bound, input string tag);
    int k = 0;
    while (rise_bytes.size() < n && k < bound) begin
      tick();
      k++;
    end
    tick();
    checkOutput(tag, rise_bytes.size(), n);
  endtask

  task automatic waitFall(input int bound, input string tag);
    int k = 0;
    while (snd_irq && k < bound) begin
      tick();
      k++;
    end
    checkOutput(tag, snd_irq, 0);
  endtask

  task automatic pulseRead(input int n);
    snd_rd = 1'b1;
    ticks(n);
    snd_rd = 1'b0;
    tick();
  endtask

  logic [7:0] b_vals[4] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
  int         irq_seen;

  initial begin
    // Reset state
    rst = 1'b1;
    ticks(3);
    checkOutput("rst_latch", snd_latch, 8'h00);
    checkOutput("rst_irq",   snd_irq, 0);
    checkOutput("rst_empty", fifo_empty, 1);
    checkOutput("rst_full",  fifo_full, 0);
    checkOutput("rst_ovf",   ovf, 0);
    checkOutput("rst_tout",  tout, 0);
    rst = 1'b0;
    tick();

    // Single long strobe of 0x5A
    cpu_dout = 8'h5A;
    latch_we = 1'b1;
    tick();
    checkOutput("w1_irq_early", snd_irq, 0);
    checkOutput("w1_not_empty", fifo_empty, 0);
    tick();
    checkOutput("w1_latch", snd_latch, 8'h5A);
    checkOutput("w1_irq",   snd_irq, 1);
    checkOutput("w1_empty", fifo_empty, 1);
    ticks(6);
    latch_we = 1'b0;
    waitFall(40, "w1_fall");
    tick();
    checkOutput("w1_irq_len", last_len, 16);
    checkOutput("w1_one_byte", rise_bytes.size(), 1);

    // Read acknowledge in WAIT_RD
    pulseRead(3);
    irq_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (snd_irq) irq_seen = 1;
      tick();
    end
    checkOutput("rd_irq_low", irq_seen, 0);
    ticks(40);
    checkOutput("rd_no_tout", tout, 0);
    checkOutput("rd_empty", fifo_empty, 1);
    checkOutput("rd_latch_hold", snd_latch, 8'h5A);
    checkOutput("rd_no_rise", rise_bytes.size(), 1);

    // Three back-to-back bytes, no reads: each times out
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    waitRise(3, 200, "to_rise2");
    checkOutput("to_tout_set", tout, 1);
    waitRise(4, 200, "to_rise3");
    checkOutput("to_byte1", rise_bytes[1], 8'h01);
    checkOutput("to_byte2", rise_bytes[2], 8'h02);
    checkOutput("to_byte3", rise_bytes[3], 8'h03);
    checkOutput("to_space12", rise_times[2] - rise_times[1], 53);
    checkOutput("to_space23", rise_times[3] - rise_times[2], 53);
    ticks(60);
    checkOutput("to_tout_sticky", tout, 1);
    checkOutput("to_empty", fifo_empty, 1);

    // Overflow while first byte waits for a read
    applyStimulus(8'hA1);
    waitRise(5, 20, "ov_rise");
    checkOutput("ov_latch_a1", snd_latch, 8'hA1);
    waitFall(40, "ov_fall");
    tick();
    applyStimulus(8'hB1);
    applyStimulus(8'hB2);
    applyStimulus(8'hB3);
    checkOutput("ov_full_3", fifo_full, 0);
    applyStimulus(8'hB4);
    checkOutput("ov_full_4", fifo_full, 1);
    checkOutput("ov_ovf_4", ovf, 0);
    applyStimulus(8'hB5);
    checkOutput("ov_ovf_5", ovf, 1);
    checkOutput("ov_full_5", fifo_full, 1);
    pulseRead(2);
    for (int k = 0; k < 4; k++) begin
      waitRise(6 + k, 80, "ov_drain_rise");
      checkOutput("ov_drain_byte", rise_bytes[5 + k], b_vals[k]);
      waitFall(40, "ov_drain_fall");
      tick();
      pulseRead(2);
    end
    ticks(100);
    checkOutput("ov_no_b5", rise_bytes.size(), 9);
    checkOutput("ov_empty", fifo_empty, 1);
    checkOutput("ov_sticky", ovf, 1);

    // Read during the IRQ phase
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checkOutput("r2_tout_clr", tout, 0);
    checkOutput("r2_ovf_clr", ovf, 0);
    applyStimulus(8'hC1);
    waitRise(10, 20, "ir_rise");
    checkOutput("ir_latch", snd_latch, 8'hC1);
    ticks(4);
    pulseRead(2);
    waitFall(40, "ir_fall");
    tick();
    checkOutput("ir_irq_len", last_len, 16);
    ticks(40);
    checkOutput("ir_no_tout", tout, 0);

    // Reset during IRQ with two bytes queued
    applyStimulus(8'hD1);
    applyStimulus(8'hD2);
    applyStimulus(8'hD3);
    checkOutput("mr_irq_pre", snd_irq, 1);
    checkOutput("mr_empty_pre", fifo_empty, 0);
    checkOutput("mr_rises_pre", rise_bytes.size(), 11);
    rst = 1'b1;
    tick();
    checkOutput("mr_irq", snd_irq, 0);
    checkOutput("mr_latch", snd_latch, 8'h00);
    checkOutput("mr_empty", fifo_empty, 1);
    checkOutput("mr_ovf", ovf, 0);
    checkOutput("mr_tout", tout, 0);
    rst = 1'b0;
    ticks(100);
    checkOutput("mr_no_rise", rise_bytes.size(), 11);
    checkOutput("mr_irq_quiet", snd_irq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
